// File: rtl/operand_pkg.sv
// Shared definitions for the operand entry stage and the add/subtract display stage.
// Holds the entry-state encoding, default operand width and op codes.
package operand_pkg;

    localparam int unsigned DATA_W_DEFAULT = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Entry order is A -> B -> OP -> SHOW, then back to A.
    function automatic state_t next_step(input state_t s);
        state_t n;
        case (s)
            S_A:     n = S_B;
            S_B:     n = S_OP;
            S_OP:    n = S_SHOW;
            default: n = S_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one pushbutton.
// Emits a single-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = stable;
    assign press = stable & ~stable_d;

endmodule

// File: rtl/operand_entry.sv
// Collects operand A, operand B and the op select from switches and two buttons,
// presenting them as registered values to the add/subtract display stage.
module operand_entry
    import operand_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_enter,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_op,
    output logic [1:0]        step,
    output logic              show_valid
);

    logic   enter_press;
    logic   clear_press;
    logic   enter_level;
    logic   clear_level;
    logic   unused_levels;
    state_t state;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_raw(btn_enter),
        .level  (enter_level),
        .press  (enter_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clk_in (clk_in),
        .rst    (rst),
        .btn_raw(btn_clear),
        .level  (clear_level),
        .press  (clear_press)
    );

    assign unused_levels = &{1'b0, enter_level, clear_level};

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= S_A;
            out_a      <= '0;
            out_b      <= '0;
            out_op     <= OP_ADD;
            show_valid <= 1'b0;
        end else if (clear_press) begin
            // Clear outranks a coincident enter; the enter is dropped.
            state      <= S_A;
            out_a      <= '0;
            out_b      <= '0;
            out_op     <= OP_ADD;
            show_valid <= 1'b0;
        end else if (enter_press) begin
            case (state)
                S_A:     out_a  <= sw;
                S_B:     out_b  <= sw;
                S_OP:    out_op <= sw[0];
                default: ;
            endcase
            state      <= next_step(state);
            show_valid <= (state == S_OP);
        end
    end

    assign step = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

    localparam int unsigned DATA_W = 4;

    logic              clk_in;
    logic              rst;
    logic [DATA_W-1:0] sw;
    logic              btn_enter;
    logic              btn_clear;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_op;
    logic [1:0]        step;
    logic              show_valid;

    int n_checks = 0;
    int n_errors = 0;

    operand_entry #(
        .DATA_W         (DATA_W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .step      (step),
        .show_valid(show_valid)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Hold enter with sw=v for 'hold' cycles, release, and let the release settle.
    task automatic do_enter(input logic [3:0] v, input int hold,
                            output int presses, output int first_at);
        presses  = 0;
        first_at = 0;
        sw        = v;
        btn_enter = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk_in);
            if (dut.enter_press) begin
                presses++;
                if (first_at == 0) first_at = k;
            end
        end
        btn_enter = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (dut.enter_press) presses++;
        end
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            btn_enter = ~btn_enter;
            btn_clear = (i % 2) == 0;
            if (dut.enter_press || dut.clear_press) pulses++;
        end
        @(negedge clk_in);
        n_checks++;
        if ({out_a, out_b, out_op, step, show_valid} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got a=%0d b=%0d op=%0d step=%0d sv=%0d, expected all 0",
                     out_a, out_b, out_op, step, show_valid);
        end
        rst = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (dut.enter_press || dut.clear_press) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL reset_no_press: got %0d pulses, expected 0", pulses);
        end
        n_checks++;
        if (step !== 2'd0 || show_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_step: got step=%0d sv=%0d, expected 0/0", step, show_valid);
        end
    endtask

    task automatic test_full_entry();
        int p;
        int f;
        do_enter(4'b0101, 12, p, f);
        n_checks++;
        if (p !== 1 || f !== 6) begin
            n_errors++;
            $display("FAIL entry_a_pulse: got count=%0d at=%0d, expected 1 at 6", p, f);
        end
        n_checks++;
        if (out_a !== 4'd5 || step !== 2'd1 || show_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL entry_a: got a=%0d step=%0d sv=%0d, expected 5/1/0", out_a, step, show_valid);
        end
        do_enter(4'b0011, 12, p, f);
        n_checks++;
        if (p !== 1 || f !== 6) begin
            n_errors++;
            $display("FAIL entry_b_pulse: got count=%0d at=%0d, expected 1 at 6", p, f);
        end
        n_checks++;
        if (out_b !== 4'd3 || step !== 2'd2 || show_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL entry_b: got b=%0d step=%0d sv=%0d, expected 3/2/0", out_b, step, show_valid);
        end
        do_enter(4'b0001, 12, p, f);
        n_checks++;
        if (p !== 1 || f !== 6) begin
            n_errors++;
            $display("FAIL entry_op_pulse: got count=%0d at=%0d, expected 1 at 6", p, f);
        end
        n_checks++;
        if (out_a !== 4'd5 || out_b !== 4'd3 || out_op !== 1'b1 || step !== 2'd3 || show_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL entry_show: got a=%0d b=%0d op=%0d step=%0d sv=%0d, expected 5/3/1/3/1",
                     out_a, out_b, out_op, step, show_valid);
        end
    endtask

    task automatic test_bounce();
        int p;
        int f;
        p = 0;
        for (int i = 0; i < 20; i++) begin
            btn_enter = ((i / 2) % 2) == 0;
            @(negedge clk_in);
            if (dut.enter_press) p++;
        end
        btn_enter = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (dut.enter_press) p++;
        end
        n_checks++;
        if (p !== 0 || step !== 2'd3) begin
            n_errors++;
            $display("FAIL bounce_reject: got %0d presses step=%0d, expected 0 presses step=3", p, step);
        end
        do_enter(4'b1010, 10, p, f);
        n_checks++;
        if (p !== 1) begin
            n_errors++;
            $display("FAIL bounce_held: got %0d presses, expected 1", p);
        end
        n_checks++;
        if (step !== 2'd0 || out_a !== 4'd5 || show_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_wrap: got step=%0d a=%0d sv=%0d, expected 0/5/0", step, out_a, show_valid);
        end
    endtask

    task automatic test_clear_priority();
        int p;
        int f;
        int pc;
        int pe;
        do_enter(4'd9, 12, p, f);
        do_enter(4'd2, 12, p, f);
        n_checks++;
        if (step !== 2'd2 || out_a !== 4'd9 || out_b !== 4'd2) begin
            n_errors++;
            $display("FAIL clear_setup: got step=%0d a=%0d b=%0d, expected 2/9/2", step, out_a, out_b);
        end
        sw = 4'b0001;
        pc = 0;
        pe = 0;
        btn_clear = 1'b1;
        btn_enter = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (dut.clear_press) pc++;
            if (dut.enter_press) pe++;
        end
        btn_clear = 1'b0;
        btn_enter = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk_in);
        n_checks++;
        if (pc !== 1 || pe !== 1) begin
            n_errors++;
            $display("FAIL clear_pulses: got clear=%0d enter=%0d, expected 1/1", pc, pe);
        end
        n_checks++;
        if ({out_a, out_b, out_op, step, show_valid} !== 12'd0) begin
            n_errors++;
            $display("FAIL clear_wins: got a=%0d b=%0d op=%0d step=%0d sv=%0d, expected all 0",
                     out_a, out_b, out_op, step, show_valid);
        end
    endtask

    task automatic test_wrap();
        int p;
        int f;
        do_enter(4'd9, 12, p, f);
        do_enter(4'd4, 12, p, f);
        do_enter(4'd0, 12, p, f);
        n_checks++;
        if (step !== 2'd3 || out_a !== 4'd9 || out_b !== 4'd4 || out_op !== 1'b0 || show_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_setup: got step=%0d a=%0d b=%0d op=%0d sv=%0d, expected 3/9/4/0/1",
                     step, out_a, out_b, out_op, show_valid);
        end
        do_enter(4'd6, 12, p, f);
        n_checks++;
        if (step !== 2'd0 || out_a !== 4'd9 || out_b !== 4'd4 || show_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_hold: got step=%0d a=%0d b=%0d sv=%0d, expected 0/9/4/0",
                     step, out_a, out_b, show_valid);
        end
        do_enter(4'b1111, 12, p, f);
        n_checks++;
        if (step !== 2'd1 || out_a !== 4'd15) begin
            n_errors++;
            $display("FAIL wrap_reload: got step=%0d a=%0d, expected 1/15", step, out_a);
        end
    endtask

    task automatic test_mid_reset();
        int p;
        sw = 4'd7;
        btn_enter = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk_in);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) @(negedge clk_in);
        n_checks++;
        if ({out_a, out_b, out_op, step, show_valid} !== 12'd0) begin
            n_errors++;
            $display("FAIL midrst_state: got a=%0d b=%0d op=%0d step=%0d sv=%0d, expected all 0",
                     out_a, out_b, out_op, step, show_valid);
        end
        rst = 1'b0;
        p = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (dut.enter_press) p++;
        end
        btn_enter = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (dut.enter_press) p++;
        end
        n_checks++;
        if (p !== 1) begin
            n_errors++;
            $display("FAIL midrst_press: got %0d presses, expected 1", p);
        end
        n_checks++;
        if (step !== 2'd1 || out_a !== 4'd7 || out_b !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_entry: got step=%0d a=%0d b=%0d, expected 1/7/0", step, out_a, out_b);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sw        = '0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_full_entry();
        test_bounce();
        test_clear_priority();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
